// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair.
package pwm_pkg;

   // Nominal PWM period in clk cycles; generator and capture default to the same value.
   localparam int PWM_INTERVAL_DEF = 1250;

   // Capture FSM states.
   typedef enum logic [1:0] {
      SEEK = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// PWM capture bundle: the incoming line plus the measured results.
interface pwm_capture_if #(
   parameter int VAL_W = 11,
   parameter int PER_W = 12
);
   logic             pwm_in;
   logic [VAL_W-1:0] duty_value;
   logic [PER_W-1:0] period;
   logic             valid;
   logic             stuck;

   // Source of the line / consumer of the measurements.
   modport master (output pwm_in, input duty_value, period, valid, stuck);
   // The capture block itself.
   modport slave  (input pwm_in, output duty_value, period, valid, stuck);
endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus edge-detect flop for an asynchronous line.
// level, rise and fall are all registered and mutually aligned: rise/fall
// mark the first cycle in which level shows its new value.
module pwm_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic       s1, s2, s3;
   // Tracks that s2/s3 hold real samples; the zeros loaded by reset must
   // not be mistaken for a low phase of the line (false rise after reset).
   logic [2:0] primed;

   // Synchronize, delay one more stage and register the edge flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         primed <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         s1     <= din;
         s2     <= s1;
         s3     <= s2;
         primed <= {primed[1:0], 1'b1};
         rise   <= primed[2] &  s2 & ~s3;
         fall   <= primed[2] & ~s2 &  s3;
      end
   end

   assign level = s3;

endmodule

// File: rtl/pwm_capture.sv
// Recovers duty value and period from one PWM line (encoder: high while
// counter <= value, so high time = value+1). Reports once per complete
// rising-to-rising period and flags a line that stops toggling.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int PWM_INTERVAL = PWM_INTERVAL_DEF,
   parameter int TIMEOUT      = 2 * PWM_INTERVAL
) (
   input logic          clk,
   input logic          rst,
   pwm_capture_if.slave cap
);
   localparam int VAL_W = $clog2(PWM_INTERVAL);
   localparam int PER_W = $clog2(TIMEOUT + 1);

   localparam logic [PER_W-1:0] CNT_MAX  = PER_W'(TIMEOUT);
   localparam logic [PER_W-1:0] CNT_ONE  = PER_W'(1);
   localparam logic [PER_W-1:0] HI_LIMIT = PER_W'(PWM_INTERVAL);
   localparam logic [VAL_W-1:0] DUTY_MAX = VAL_W'(PWM_INTERVAL - 1);

   localparam logic [1:0] S_SEEK = 2'(SEEK);
   localparam logic [1:0] S_HIGH = 2'(HIGH);
   localparam logic [1:0] S_LOW  = 2'(LOW);

   logic             level, rise, fall;
   logic [1:0]       state;
   logic [PER_W-1:0] hi_cnt, lo_cnt, idle_cnt;
   logic [PER_W-1:0] idle_nxt;
   logic             timeout_hit;
   logic [PER_W:0]   per_sum;
   logic [VAL_W-1:0] duty_calc;
   logic [PER_W-1:0] per_calc;
   logic [VAL_W-1:0] duty_q;
   logic [PER_W-1:0] period_q;
   logic             valid_q, stuck_q;

   pwm_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (cap.pwm_in),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] x);
      return (x == CNT_MAX) ? x : x + CNT_ONE;
   endfunction

   // Idle tracking and the values a closing rise would publish.
   always_comb begin
      idle_nxt    = (rise | fall) ? '0 : sat_inc(idle_cnt);
      // Fires once on the transition into TIMEOUT; a saturated counter stays quiet.
      timeout_hit = !(rise | fall) && (idle_cnt != CNT_MAX) && (idle_nxt == CNT_MAX);
      duty_calc   = (hi_cnt > HI_LIMIT) ? DUTY_MAX : VAL_W'(hi_cnt - CNT_ONE);
      per_sum     = {1'b0, hi_cnt} + {1'b0, lo_cnt};
      // Both halves can approach TIMEOUT, so clamp rather than wrap.
      per_calc    = (per_sum > {1'b0, CNT_MAX}) ? CNT_MAX : per_sum[PER_W-1:0];
   end

   // FSM, phase counters and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_SEEK;
         hi_cnt   <= '0;
         lo_cnt   <= '0;
         idle_cnt <= '0;
         duty_q   <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         valid_q  <= 1'b0;
         idle_cnt <= idle_nxt;
         if (timeout_hit) begin
            state    <= S_SEEK;
            stuck_q  <= 1'b1;
            duty_q   <= level ? DUTY_MAX : '0;
            period_q <= '0;
            valid_q  <= 1'b1;
         end else begin
            case (state)
               S_SEEK: begin
                  if (rise) begin
                     state   <= S_HIGH;
                     hi_cnt  <= CNT_ONE;
                     lo_cnt  <= '0;
                     stuck_q <= 1'b0;
                  end
               end
               S_HIGH: begin
                  if (fall) begin
                     state  <= S_LOW;
                     lo_cnt <= CNT_ONE;
                  end else if (level) begin
                     hi_cnt <= sat_inc(hi_cnt);
                  end
               end
               S_LOW: begin
                  if (rise) begin
                     duty_q   <= duty_calc;
                     period_q <= per_calc;
                     valid_q  <= 1'b1;
                     state    <= S_HIGH;
                     hi_cnt   <= CNT_ONE;
                     lo_cnt   <= '0;
                  end else begin
                     lo_cnt <= sat_inc(lo_cnt);
                  end
               end
               default: state <= S_SEEK;
            endcase
         end
      end
   end

   assign cap.duty_value = duty_q;
   assign cap.period     = period_q;
   assign cap.valid      = valid_q;
   assign cap.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed generator loopback with a timestamp-based
// reference model checked every cycle, plus hand-computed literal checks.
module tb_pwm_capture;
   localparam int PI    = 1250;
   localparam int TO    = 2 * PI;
   localparam int VAL_W = $clog2(PI);
   localparam int PER_W = $clog2(TO + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;

   pwm_capture_if #(.VAL_W(VAL_W), .PER_W(PER_W)) bus ();

   pwm_capture #(.PWM_INTERVAL(PI), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .cap (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int nvalid = 0;

   // Generator state: value is latched at each counter wrap, like the encoder.
   int gcnt    = PI - 1;
   int gval    = 0;
   int cur_val = 0;
   bit gen_en  = 1'b0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // One clock: advance the generator just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      gcnt = (gcnt == PI - 1) ? 0 : gcnt + 1;
      if (gcnt == 0) cur_val = gval;
      bus.pwm_in = gen_en && (gcnt <= cur_val);
   endtask

   task automatic wait_valid(input string nm, input int budget,
                             output int du, output int pe, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!bus.valid && cyc < budget);
      du = int'(bus.duty_value);
      pe = int'(bus.period);
      if (!bus.valid) begin
         checks++;
         errors++;
         $display("FAIL %s no valid within %0d cycles", nm, budget);
      end
   endtask

   // Reference model: the line as seen 3 cycles late, edges only between
   // samples taken after reset; periods measured by edge timestamps.
   initial begin
      bit d[5];
      int n, idle, t, rise_t, fall_t;
      bit have_r, have_f, lvl, er, ef, fire, m_valid;
      int m_duty, m_per, m_stuck;
      n = 0; idle = 0; t = 0; rise_t = 0; fall_t = 0;
      have_r = 0; have_f = 0; m_duty = 0; m_per = 0; m_stuck = 0;
      forever begin
         @(posedge clk);
         t++;
         m_valid = 1'b0;
         if (rst) begin
            n = 0; idle = 0; have_r = 0; have_f = 0;
            m_duty = 0; m_per = 0; m_stuck = 0;
         end else begin
            for (int i = 4; i > 0; i--) d[i] = d[i-1];
            d[0] = bus.pwm_in;
            if (n < 5) n++;
            lvl  = (n >= 4) ? d[3] : 1'b0;
            er   = (n >= 5) &&  d[3] && !d[4];
            ef   = (n >= 5) && !d[3] &&  d[4];
            fire = 1'b0;
            if (er || ef) idle = 0;
            else if (idle < TO) begin
               idle++;
               fire = (idle == TO);
            end
            if (fire) begin
               m_stuck = 1; m_duty = lvl ? PI - 1 : 0; m_per = 0;
               m_valid = 1'b1; have_r = 0;
            end else if (er) begin
               if (have_r && have_f) begin
                  m_duty  = imin(fall_t - rise_t - 1, PI - 1);
                  m_per   = imin(t - rise_t, TO);
                  m_valid = 1'b1;
               end
               have_r = 1; have_f = 0; rise_t = t; m_stuck = 0;
            end else if (ef && have_r && !have_f) begin
               have_f = 1; fall_t = t;
            end
         end
         @(negedge clk);
         if (bus.valid) nvalid++;
         chk("cyc_valid",  int'(bus.valid),      int'(m_valid));
         chk("cyc_stuck",  int'(bus.stuck),      m_stuck);
         chk("cyc_duty",   int'(bus.duty_value), m_duty);
         chk("cyc_period", int'(bus.period),     m_per);
      end
   end

   // Directed sequence with literal expectations.
   initial begin
      int k, du, pe, v0;
      bus.pwm_in = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_duty",   int'(bus.duty_value), 0);
      chk("rst_period", int'(bus.period),     0);
      chk("rst_valid",  int'(bus.valid),      0);
      chk("rst_stuck",  int'(bus.stuck),      0);

      // Line held low from reset: stuck exactly TIMEOUT cycles later, one pulse.
      rst = 1'b0;
      k = 0;
      while (!bus.stuck && k < TO + 100) begin tick(); k++; end
      chk("low_stuck_cycle", k, TO);
      chk("low_stuck_duty",  int'(bus.duty_value), 0);
      chk("low_stuck_per",   int'(bus.period),     0);
      chk("low_stuck_valid", int'(bus.valid),      1);
      v0 = nvalid;
      repeat (300) tick();
      chk("low_one_pulse", nvalid - v0, 1);

      // Loopback value 300: stuck clears on first rise, valid one period later.
      gval = 300; gen_en = 1'b1; gcnt = PI - 1;
      tick();
      k = 0;
      while (bus.stuck && k < 10) begin tick(); k++; end
      chk("clear_latency",  k, 4);
      chk("clear_no_valid", int'(bus.valid), 0);
      wait_valid("v300a", 2 * PI, du, pe, k);
      chk("v300a_lat", k, PI); chk("v300a_duty", du, 300); chk("v300a_per", pe, PI);
      wait_valid("v300b", 2 * PI, du, pe, k);
      chk("v300b_lat", k, PI); chk("v300b_duty", du, 300); chk("v300b_per", pe, PI);

      // One-cycle high.
      gval = 0;
      wait_valid("v0a", 2 * PI, du, pe, k);
      wait_valid("v0b", 2 * PI, du, pe, k);
      chk("v0_duty", du, 0); chk("v0_per", pe, PI); chk("v0_lat", k, PI);

      // One-cycle low.
      gval = PI - 2;
      wait_valid("v1248a", 2 * PI, du, pe, k);
      wait_valid("v1248b", 2 * PI, du, pe, k);
      chk("v1248_duty", du, PI - 2); chk("v1248_per", pe, PI);

      // Constant high: timeout reports full duty, one pulse.
      gval = PI - 1;
      k = 0;
      while (!bus.stuck && k < 3 * TO) begin tick(); k++; end
      chk("hi_stuck",       int'(bus.stuck),      1);
      chk("hi_stuck_duty",  int'(bus.duty_value), PI - 1);
      chk("hi_stuck_per",   int'(bus.period),     0);
      chk("hi_stuck_valid", int'(bus.valid),      1);
      v0 = nvalid;
      repeat (300) tick();
      chk("hi_one_pulse", nvalid - v0, 1);

      // Recover with value 500.
      gval = 500;
      k = 0;
      while (bus.stuck && k < 3 * PI) begin tick(); k++; end
      chk("rec_cleared",  int'(bus.stuck), 0);
      chk("rec_no_valid", int'(bus.valid), 0);
      wait_valid("v500", 2 * PI, du, pe, k);
      chk("v500_lat", k, PI); chk("v500_duty", du, 500); chk("v500_per", pe, PI);

      // Mid-stream change 300 -> 900.
      gval = 300;
      wait_valid("m300a", 2 * PI, du, pe, k);
      wait_valid("m300b", 2 * PI, du, pe, k);
      chk("m300_duty", du, 300);
      repeat (417) tick();
      gval = 900;
      wait_valid("mtrans", 2 * PI, du, pe, k);
      chk("mtrans_duty", du, 300); chk("mtrans_lat", k, PI - 417);
      wait_valid("m900", 2 * PI, du, pe, k);
      chk("m900_duty", du, 900); chk("m900_per", pe, PI); chk("m900_lat", k, PI);

      // Reset for one cycle while in HIGH.
      k = 0;
      while (gcnt != 100 && k < 2 * PI) begin tick(); k++; end
      rst = 1'b1;
      tick();
      chk("mrst_duty",  int'(bus.duty_value), 0);
      chk("mrst_per",   int'(bus.period),     0);
      chk("mrst_valid", int'(bus.valid),      0);
      chk("mrst_stuck", int'(bus.stuck),      0);
      rst = 1'b0;
      wait_valid("post_rst", 3 * PI, du, pe, k);
      chk("post_rst_lat",  k, 2403);
      chk("post_rst_duty", du, 900);
      chk("post_rst_per",  pe, PI);

      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
